// File: rtl/hazard_stall_controller_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// The FORWARDING_EN build option lives in hazard_stall_controller.sv.
package hazard_stall_controller_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_ERROR    = 2'd2
  } state_t;

  // Branch kinds produced by ID decode; shared so decode and EXE agree on encoding.
  typedef enum logic [1:0] {
    NO_BRANCH = 2'd0,
    BEZ       = 2'd1,
    BNE       = 2'd2,
    JMP       = 2'd3
  } branch_t;

endpackage

// File: rtl/hazard_stall_controller_if.sv
// Pipeline-to-controller bundle: stage register info in, stall/flush/freeze controls out.
// mem_start/mem_ready is a request/complete handshake: mem_start pulses once, mem_ready ends the access.
interface hazard_stall_controller_if
  import hazard_stall_controller_pkg::*;
#(
  parameter int AW     = REG_AW,
  parameter int PERF_W = 16
);
  logic [AW-1:0]     id_src1;
  logic [AW-1:0]     id_src2;
  logic              id_uses_src2;
  logic [AW-1:0]     exe_dest;
  logic              exe_wb_en;
  logic              exe_mem_r_en;
  logic [AW-1:0]     mem_dest;
  logic              mem_wb_en;
  logic              mem_op;
  logic              mem_ready;
  logic              branch_taken;
  logic              pc_freeze;
  logic              if_id_freeze;
  logic              id_exe_bubble;
  logic              if_id_flush;
  logic              freeze_all;
  logic              mem_start;
  logic              mem_err;
  logic [PERF_W-1:0] stall_cnt;
  state_t            dbgState;
  logic [1:0]        dbgRaw;

  modport slave (
    input  id_src1, id_src2, id_uses_src2, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_op, mem_ready, branch_taken,
    output pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, freeze_all,
           mem_start, mem_err, stall_cnt, dbgState, dbgRaw
  );

  modport master (
    output id_src1, id_src2, id_uses_src2, exe_dest, exe_wb_en, exe_mem_r_en,
           mem_dest, mem_wb_en, mem_op, mem_ready, branch_taken,
    input  pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, freeze_all,
           mem_start, mem_err, stall_cnt, dbgState, dbgRaw
  );
endinterface

// File: rtl/hazard_stall_controller_raw_detect.sv
// Read-after-write comparator of the ID sources against the EXE and MEM destinations.
module hazard_stall_controller_raw_detect
  import hazard_stall_controller_pkg::*;
#(
  parameter int AW = REG_AW
) (
  input  logic [AW-1:0] idSrc1,
  input  logic [AW-1:0] idSrc2,
  input  logic          idUsesSrc2,
  input  logic [AW-1:0] exeDest,
  input  logic          exeWbEn,
  input  logic [AW-1:0] memDest,
  input  logic          memWbEn,
  output logic          rawExe,
  output logic          rawMem
);
  // r0 is hardwired zero, so a write to it never creates a dependency.
  assign rawExe = exeWbEn && (exeDest != '0) &&
                  ((idSrc1 == exeDest) || (idUsesSrc2 && (idSrc2 == exeDest)));
  assign rawMem = memWbEn && (memDest != '0) &&
                  ((idSrc1 == memDest) || (idUsesSrc2 && (idSrc2 == memDest)));
endmodule

// File: rtl/hazard_stall_controller.sv
// Stall/flush sequencer: RAW stalls, branch flush, SRAM freeze with watchdog, stall counter.
// Define FORWARDING_EN when the forwarding network is present (load-use stalls only).
module hazard_stall_controller
  import hazard_stall_controller_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7,
  parameter int PERF_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  hazard_stall_controller_if.slave  bus
);
  state_t            state, nextState;
  logic [CNT_W-1:0]  waitCnt;
  logic [PERF_W-1:0] stallCnt;
  logic              rawExe, rawMem, loadUse, hazard;
  logic              pcFreeze, ifIdFreeze, idExeBubble, ifIdFlush, freezeAll, memStart;

  hazard_stall_controller_raw_detect #(.AW(REG_AW)) u_raw (
    .idSrc1     (bus.id_src1),
    .idSrc2     (bus.id_src2),
    .idUsesSrc2 (bus.id_uses_src2),
    .exeDest    (bus.exe_dest),
    .exeWbEn    (bus.exe_wb_en),
    .memDest    (bus.mem_dest),
    .memWbEn    (bus.mem_wb_en),
    .rawExe     (rawExe),
    .rawMem     (rawMem)
  );

  assign loadUse = rawExe & bus.exe_mem_r_en;
`ifdef FORWARDING_EN
  assign hazard = loadUse;
`else
  // loadUse is a subset of rawExe; without forwarding every dependency stalls.
  assign hazard = rawExe | rawMem | loadUse;
`endif

  always_comb begin
    nextState   = state;
    pcFreeze    = 1'b0;
    ifIdFreeze  = 1'b0;
    idExeBubble = 1'b0;
    ifIdFlush   = 1'b0;
    freezeAll   = 1'b0;
    memStart    = 1'b0;
    unique case (state)
      S_RUN: begin
        if (bus.mem_op) begin
          memStart  = 1'b1;
          freezeAll = 1'b1;
          nextState = S_MEM_WAIT;
        end else if (bus.branch_taken) begin
          ifIdFlush   = 1'b1;
          idExeBubble = 1'b1;
        end else if (hazard) begin
          pcFreeze    = 1'b1;
          ifIdFreeze  = 1'b1;
          idExeBubble = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        if (bus.mem_ready) begin
          nextState = S_RUN;
        end else begin
          freezeAll = 1'b1;
          if (waitCnt == CNT_W'(TIMEOUT - 1)) nextState = S_ERROR;
        end
      end
      S_ERROR:  freezeAll = 1'b1;
      default:  nextState = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      waitCnt  <= '0;
      stallCnt <= '0;
    end else begin
      state <= nextState;
      if (state == S_MEM_WAIT) waitCnt <= waitCnt + 1'b1;
      else                     waitCnt <= '0;
      if ((pcFreeze || freezeAll) && !(&stallCnt)) stallCnt <= stallCnt + 1'b1;
    end
  end

  // Controls are combinational, so they are masked explicitly while reset is held.
  assign bus.pc_freeze     = rst_n & pcFreeze;
  assign bus.if_id_freeze  = rst_n & ifIdFreeze;
  assign bus.id_exe_bubble = rst_n & idExeBubble;
  assign bus.if_id_flush   = rst_n & ifIdFlush;
  assign bus.freeze_all    = rst_n & freezeAll;
  assign bus.mem_start     = rst_n & memStart;
  assign bus.mem_err       = rst_n & (state == S_ERROR);
  assign bus.stall_cnt     = stallCnt;
  assign bus.dbgState      = state;
  assign bus.dbgRaw        = {rawMem, rawExe};
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Directed bench for hazard_stall_controller: vector table plus multi-cycle sequences.
module tb_hazard_stall_controller;
  import hazard_stall_controller_pkg::*;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  hazard_stall_controller_if #(.PERF_W(4)) bus ();

  hazard_stall_controller #(.TIMEOUT(8), .CNT_W(7), .PERF_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] src1, src2;
    logic       uses2;
    logic [4:0] exeDest;
    logic       exeWb, exeLd;
    logic [4:0] memDest;
    logic       memWb, br;
    logic [5:0] exp;   // {pc_freeze, if_id_freeze, id_exe_bubble, if_id_flush, freeze_all, mem_start}
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clearInputs();
    bus.id_src1 = '0; bus.id_src2 = '0; bus.id_uses_src2 = 1'b0;
    bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
    bus.mem_dest = '0; bus.mem_wb_en = 1'b0; bus.mem_op = 1'b0;
    bus.mem_ready = 1'b0; bus.branch_taken = 1'b0;
  endtask

  task automatic loadUse();
    bus.id_src1 = 5'd3; bus.exe_dest = 5'd3; bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
  endtask

  task automatic doReset();
    clearInputs();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic logic [5:0] ctl();
    return {bus.pc_freeze, bus.if_id_freeze, bus.id_exe_bubble,
            bus.if_id_flush, bus.freeze_all, bus.mem_start};
  endfunction

  initial begin
    clearInputs();
    vecs[0] = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 6'b000000};
    vecs[1] = '{5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 6'b111000};
    vecs[2] = '{5'd3, 5'd0, 1'b0, 5'd3, 1'b1, 1'b1, 5'd0, 1'b0, 1'b1, 6'b001100};
    vecs[3] = '{5'd1, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, FWD ? 6'b000000 : 6'b111000};
    vecs[4] = '{5'd1, 5'd5, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 6'b000000};
    vecs[5] = '{5'd7, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, FWD ? 6'b000000 : 6'b111000};
    vecs[6] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 6'b000000};
    vecs[7] = '{5'd9, 5'd0, 1'b0, 5'd9, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 6'b000000};
    vecs[8] = '{5'd2, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1, 6'b001100};
    vecs[9] = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 6'b000000};

    // Reset: outputs masked even with a load-use hazard and mem_op on the inputs.
    loadUse();
    bus.mem_op = 1'b1;
    tick();
    chk("reset_ctl", 32'(ctl()), 32'd0);
    chk("reset_err", 32'(bus.mem_err), 32'd0);
    chk("reset_cnt", 32'(bus.stall_cnt), 32'd0);
    chk("reset_state", 32'(bus.dbgState), 32'(S_RUN));
    doReset();

    // Combinational vectors, all in S_RUN.
    for (int i = 0; i < 10; i++) begin
      bus.id_src1 = vecs[i].src1; bus.id_src2 = vecs[i].src2; bus.id_uses_src2 = vecs[i].uses2;
      bus.exe_dest = vecs[i].exeDest; bus.exe_wb_en = vecs[i].exeWb; bus.exe_mem_r_en = vecs[i].exeLd;
      bus.mem_dest = vecs[i].memDest; bus.mem_wb_en = vecs[i].memWb; bus.branch_taken = vecs[i].br;
      #2;
      chk($sformatf("vec%0d", i), 32'(ctl()), 32'(vecs[i].exp));
      tick();
    end

    // Load-use: one stall, then the load moves to MEM behind a bubble.
    doReset();
    loadUse();
    #2;
    chk("lu_stall", 32'(ctl()), 32'b111000);
    tick();
    chk("lu_cnt1", 32'(bus.stall_cnt), 32'd1);
    clearInputs();
    bus.id_src1 = 5'd3; bus.mem_dest = 5'd3; bus.mem_wb_en = 1'b1;
    #2;
    chk("lu_mem", 32'(bus.pc_freeze), FWD ? 32'd0 : 32'd1);
    tick();
    clearInputs();
    tick();
    chk("lu_cnt_end", 32'(bus.stall_cnt), FWD ? 32'd1 : 32'd2);

    // Non-load producer through EXE then MEM.
    doReset();
    bus.id_src1 = 5'd1; bus.id_src2 = 5'd5; bus.id_uses_src2 = 1'b1;
    bus.exe_dest = 5'd5; bus.exe_wb_en = 1'b1;
    #2;
    chk("nf_exe", 32'(bus.pc_freeze), FWD ? 32'd0 : 32'd1);
    tick();
    bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.mem_dest = 5'd5; bus.mem_wb_en = 1'b1;
    #2;
    chk("nf_mem", 32'(bus.pc_freeze), FWD ? 32'd0 : 32'd1);
    tick();
    bus.mem_dest = '0; bus.mem_wb_en = 1'b0;
    #2;
    chk("nf_free", 32'(bus.pc_freeze), 32'd0);
    tick();
    chk("nf_cnt", 32'(bus.stall_cnt), FWD ? 32'd0 : 32'd2);

    // SRAM handshake, ready after 4 wait cycles, with a hazard held across the freeze.
    doReset();
    bus.mem_op = 1'b1;
    loadUse();
    #2;
    chk("hs_start", 32'(ctl()), 32'b000011);
    tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("hs_wait%0d", i), 32'({bus.dbgState, ctl()}), 32'({S_MEM_WAIT, 6'b000010}));
      tick();
    end
    bus.mem_ready = 1'b1;
    #2;
    chk("hs_ready", 32'(ctl()), 32'd0);
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_op = 1'b0;
    #2;
    chk("hs_run", 32'(bus.dbgState), 32'(S_RUN));
    chk("hs_cnt", 32'(bus.stall_cnt), 32'd5);
    chk("hs_held_hazard", 32'(ctl()), 32'b111000);
    tick();
    clearInputs();

    // Watchdog: no mem_ready, error after 8 wait cycles.
    doReset();
    bus.mem_op = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("wd_wait%0d", i), 32'({bus.dbgState, bus.freeze_all, bus.mem_err}),
          32'({S_MEM_WAIT, 1'b1, 1'b0}));
      tick();
    end
    chk("wd_error", 32'({bus.dbgState, bus.freeze_all, bus.mem_err, bus.mem_start}),
        32'({S_ERROR, 1'b1, 1'b1, 1'b0}));
    bus.mem_ready = 1'b1;
    tick();
    tick();
    chk("wd_sticky", 32'({bus.dbgState, bus.freeze_all, bus.mem_err}), 32'({S_ERROR, 1'b1, 1'b1}));
    #2;
    rst_n = 1'b0;
    #1;
    chk("wd_async_clr", 32'({bus.freeze_all, bus.mem_err}), 32'd0);
    tick();
    clearInputs();
    bus.mem_ready = 1'b1;
    rst_n = 1'b1;
    tick();
    chk("wd_ready_ignored", 32'({bus.dbgState, ctl()}), 32'({S_RUN, 6'b000000}));
    clearInputs();

    // Saturation of the 4-bit stall counter.
    doReset();
    loadUse();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(bus.stall_cnt), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_15", 32'(bus.stall_cnt), 32'd15);
    clearInputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/hazard_stall_controller.md
Name: hazard_stall_controller

Overview:
- Central stall/flush sequencer for the 5-stage pipeline.
- Detects RAW hazards that the forwarding path cannot cover, flushes IF/ID on taken branches, and freezes the whole pipeline around multi-cycle SRAM accesses through a start/ready handshake with a watchdog.
- Sits beside the forwarding logic. Drives the freeze/flush/bubble controls of the PC, IF/ID, ID/EXE and the stage-register enables.

Parameters:
- REG_AW, 5, register-address width.
- TIMEOUT, 64, max S_MEM_WAIT cycles before error; legal range 2..2^CNT_W-1.
- CNT_W, 7, watchdog counter width.
- PERF_W, 16, stall-cycle counter width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_src1  in  REG_AW  ID-stage source 1.
- id_src2  in  REG_AW  ID-stage source 2.
- id_uses_src2  in  1  ID instruction reads src2 (R-type, BNE, store).
- exe_dest  in  REG_AW  EXE-stage destination.
- exe_wb_en  in  1  EXE writes back.
- exe_mem_r_en  in  1  EXE instruction is a load.
- mem_dest  in  REG_AW  MEM-stage destination.
- mem_wb_en  in  1  MEM writes back.
- mem_op  in  1  MEM stage holds a load/store.
- mem_ready  in  1  SRAM access complete.
- branch_taken  in  1  EXE resolved a taken branch/jump.
- pc_freeze  out  1  hold PC.
- if_id_freeze  out  1  hold IF/ID.
- id_exe_bubble  out  1  load NOP into ID/EXE.
- if_id_flush  out  1  clear IF/ID.
- freeze_all  out  1  hold every stage register.
- mem_start  out  1  one-cycle SRAM request pulse.
- mem_err  out  1  sticky watchdog error.
- stall_cnt  out  PERF_W  saturating count of cycles with pc_freeze or freeze_all.

Behaviour:
- Reset:
  - Async, while rst_n=0.
  - state=S_RUN, wait_cnt=0, stall_cnt=0, mem_err=0.
  - All outputs are forced 0 while rst_n=0.
  - Reset mid-access abandons the access; mem_ready is then ignored until the next mem_start.
- Hazard terms (combinational):
  - raw_exe = exe_wb_en & exe_dest!=0 & (id_src1==exe_dest | id_uses_src2 & id_src2==exe_dest).
  - raw_mem is the same with mem_*.
  - r0 never hazards.
- FSM states: S_RUN, S_MEM_WAIT, S_ERROR.
- S_RUN:
  - If mem_op: mem_start=1, freeze_all=1, next state S_MEM_WAIT, wait_cnt cleared.
  - Else if branch_taken: if_id_flush=1, id_exe_bubble=1, no freeze. The flush takes precedence over a simultaneous hazard, because the hazarding ID instruction is discarded.
  - Else if hazard: pc_freeze=1, if_id_freeze=1, id_exe_bubble=1 for that cycle. The controller re-evaluates every cycle.
- S_MEM_WAIT:
  - freeze_all = ~mem_ready; wait_cnt increments each cycle.
  - mem_ready=1: freeze_all=0, next state S_RUN; the pipeline advances at that edge.
  - mem_ready is sampled only in S_MEM_WAIT, so the minimum access is 2 cycles.
  - A branch_taken or hazard present while frozen is held by the freeze. It is acted on in the first S_RUN cycle and is not lost.
  - wait_cnt==TIMEOUT-1 without mem_ready: next state S_ERROR.
- S_ERROR:
  - freeze_all=1 and mem_err=1 permanently until reset.
  - mem_start stays 0.
- Priority: freeze_all > flush > hazard stall.
  - pc_freeze, if_id_freeze and id_exe_bubble are 0 whenever freeze_all=1.
- stall_cnt:
  - Increments at each edge where pc_freeze|freeze_all was 1.
  - Saturates at all-ones; never wraps.
- Output latency: all control outputs are Mealy/combinational from state and inputs, with zero latency. State, wait_cnt, mem_err and stall_cnt are registered.

Optional Feature:
- Macro: FORWARDING_EN.
- Defined: hazard = raw_exe & exe_mem_r_en, i.e. a load-use stall only, exactly 1 bubble.
- Undefined: hazard = raw_exe | raw_mem, so dependent instructions stall until the producer leaves MEM (up to 2 bubbles).

Decomposition:
- Shared package holds:
  - state encoding localparams S_RUN=2'd0, S_MEM_WAIT=2'd1, S_ERROR=2'd2;
  - REG_AW;
  - branch-type codes (NO_BRANCH, BEZ, BNE, JMP) used by ID decode.
- Sub-module raw_detect: combinational comparator producing raw_exe/raw_mem, instantiated once. The FSM, watchdog and perf counter stay in the top module.

Test Plan:
- Load-use: load r3 in EXE (exe_mem_r_en=1, exe_dest=3), ID src1=3 -> pc_freeze=if_id_freeze=id_exe_bubble=1 for exactly 1 cycle; stall_cnt=1.
- No-forward build: exe_dest=5, exe_wb_en=1, not a load, ID src2=5, id_uses_src2=1 -> with FORWARDING_EN no stall; without it, 2 stall cycles as the producer passes EXE and MEM; id_uses_src2=0 -> no stall; dest=0 -> never stalls.
- Branch plus hazard same cycle: branch_taken=1 with load-use -> if_id_flush=1, id_exe_bubble=1, pc_freeze=0.
- SRAM handshake: mem_op=1, mem_ready after 4 wait cycles -> mem_start pulses 1 cycle; freeze_all high 5 cycles, low on the mem_ready cycle; state returns to S_RUN; stall_cnt=5.
- Watchdog: TIMEOUT=8, mem_ready never asserted -> S_ERROR after 8 wait cycles; mem_err=1 and freeze_all=1 held; rst_n low clears both asynchronously.
- Saturation: PERF_W=4, sustained stalls 20 cycles -> stall_cnt stops at 15.
